// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use interlock unit.
package fwd_pkg;

    localparam int SAT_W          = 64;
    localparam int NUM_STAGES_DFL = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } st_e;

    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    // Select width for the default stage count; instances derive their own.
    localparam int SEL_W = sel_width(NUM_STAGES_DFL);

    // Saturating +1 for any counter narrower than SAT_W; caller keeps the low bits.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val, input int width);
        logic [SAT_W-1:0] max_v;
        max_v = (width >= SAT_W) ? {SAT_W{1'b1}} : ((SAT_W'(1) << width) - SAT_W'(1));
        return (val >= max_v) ? max_v : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/fwd_src_mux.sv
// One source operand: youngest-first match over the write-back candidates, data mux and hazard flag.
// Purely combinational; the first match is final even if its data is not ready yet.
module fwd_src_mux
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_STAGES = 2,
    parameter int ZERO_HW    = 1,
    parameter int SW         = 2
) (
    input  logic [IDX_W-1:0]            src_idx_i,
    input  logic [XLEN-1:0]             src_data_i,
    input  logic [NUM_STAGES-1:0]       stg_wr_i,
    input  logic [NUM_STAGES*IDX_W-1:0] stg_idx_i,
    input  logic [NUM_STAGES*XLEN-1:0]  stg_data_i,
    input  logic [NUM_STAGES-1:0]       stg_rdy_i,
    output logic [XLEN-1:0]             fwd_data_o,
    output logic [SW-1:0]               fwd_sel_o,
    output logic                        hazard_o
);

    logic zero_src;
    logic found;

    assign zero_src = (ZERO_HW != 0) && (src_idx_i == '0);

    always_comb begin
        fwd_data_o = src_data_i;
        fwd_sel_o  = '0;
        hazard_o   = 1'b0;
        found      = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (!found && !zero_src && stg_wr_i[k] &&
                (stg_idx_i[k*IDX_W +: IDX_W] == src_idx_i)) begin
                found      = 1'b1;
                fwd_data_o = stg_data_i[k*XLEN +: XLEN];
                fwd_sel_o  = SW'(k + 1);
                hazard_o   = !stg_rdy_i[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding for NUM_SRC sources plus load-use stall, stall-length watchdog and perf counters.
// Datapath and stall_o are zero-latency combinational; err_o and counters update on the clock edge.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int ZERO_HW    = 1,
    parameter int MAX_STALL  = 8,
    parameter int CNT_W      = 16,
    localparam int FSEL_W    = sel_width(NUM_STAGES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*IDX_W-1:0]    src_idx_i,
    input  logic [NUM_SRC*XLEN-1:0]     src_data_i,
    input  logic [NUM_STAGES-1:0]       stg_wr_i,
    input  logic [NUM_STAGES*IDX_W-1:0] stg_idx_i,
    input  logic [NUM_STAGES*XLEN-1:0]  stg_data_i,
    input  logic [NUM_STAGES-1:0]       stg_rdy_i,
    input  logic                        cnt_clr_i,
    output logic [NUM_SRC*XLEN-1:0]     fwd_data_o,
    output logic [NUM_SRC*FSEL_W-1:0]   fwd_sel_o,
    output logic                        stall_o,
    output logic                        err_o,
    output logic [CNT_W-1:0]            fwd_cnt_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    localparam int LEN_W = $clog2(MAX_STALL + 1);

    logic [NUM_SRC-1:0] hazard;
    logic               any_fwd;

    st_e                st_q, st_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [SAT_W-1:0]   fwd_inc, stall_inc;
    logic               unused_inc_hi;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_mux #(
            .XLEN       (XLEN),
            .IDX_W      (IDX_W),
            .NUM_STAGES (NUM_STAGES),
            .ZERO_HW    (ZERO_HW),
            .SW         (FSEL_W)
        ) u_mux (
            .src_idx_i  (src_idx_i[s*IDX_W +: IDX_W]),
            .src_data_i (src_data_i[s*XLEN +: XLEN]),
            .stg_wr_i   (stg_wr_i),
            .stg_idx_i  (stg_idx_i),
            .stg_data_i (stg_data_i),
            .stg_rdy_i  (stg_rdy_i),
            .fwd_data_o (fwd_data_o[s*XLEN +: XLEN]),
            .fwd_sel_o  (fwd_sel_o[s*FSEL_W +: FSEL_W]),
            .hazard_o   (hazard[s])
        );
    end

    // Several hazarding sources in one cycle are still a single stall cycle.
    assign stall_o = |hazard;
    assign any_fwd = |fwd_sel_o;

    always_comb begin
        st_d  = st_q;
        len_d = len_q;
        unique case (st_q)
            IDLE: begin
                if (stall_o) begin
                    st_d  = STALL;
                    len_d = LEN_W'(1);
                end else begin
                    len_d = '0;
                end
            end
            STALL: begin
                if (stall_o) begin
                    len_d = (len_q >= LEN_W'(MAX_STALL)) ? LEN_W'(MAX_STALL) : len_q + LEN_W'(1);
                end else begin
                    st_d  = IDLE;
                    len_d = '0;
                end
            end
            default: begin
                st_d  = IDLE;
                len_d = '0;
            end
        endcase
        err_d = err_q | (len_d == LEN_W'(MAX_STALL));
    end

    assign fwd_inc       = sat_inc(SAT_W'(fwd_cnt_q), CNT_W);
    assign stall_inc     = sat_inc(SAT_W'(stall_cnt_q), CNT_W);
    assign unused_inc_hi = ^{fwd_inc[SAT_W-1:CNT_W], stall_inc[SAT_W-1:CNT_W]};

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            fwd_cnt_d   = '0;
            stall_cnt_d = '0;
        end else if (stall_o) begin
            stall_cnt_d = stall_inc[CNT_W-1:0];
        end else if (any_fwd) begin
            fwd_cnt_d   = fwd_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q        <= IDLE;
            len_q       <= '0;
            err_q       <= 1'b0;
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            len_q       <= len_d;
            err_q       <= err_d;
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_o       = err_q;
    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
